// File: rtl/aes_pkg.sv
// Shared AES constants: FIPS-197 forward S-box table, its lookup function and the key-expansion round constants.
// Pure constants and functions; no timing or flow control of their own.
package aes_pkg;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Index 0 is unused so that round i of key expansion reads RCON[i] directly.
    localparam logic [7:0] RCON [11] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// One-byte AES forward S-box: zero-latency combinational lookup plus a 1-cycle registered copy with valid.
// No backpressure; accepts a new byte every cycle.
module aes_sbox
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in,
    input  logic       in_valid,
    output logic [7:0] out,
    output logic [7:0] out_q,
    output logic       out_valid
);

    assign out = sbox(in);

    // out_q keeps its last result while idle so downstream can re-read it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q     <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_q <= sbox(in);
            end
        end
    end

endmodule

// File: tb/tb_aes_sbox.sv
// Self-checking bench for aes_sbox against a GF(2^8) inverse + affine reference model.
module tb_aes_sbox;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       dvld;
    logic [7:0] dout;
    logic [7:0] dout_q;
    logic       dout_valid;

    logic [7:0] sw_in  [4];
    logic [7:0] sw_out [4];
    logic [7:0] sw_q   [4];
    logic       sw_v   [4];

    int passed;
    int total;

    aes_sbox dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (din),
        .in_valid  (dvld),
        .out       (dout),
        .out_q     (dout_q),
        .out_valid (dout_valid)
    );

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sw (
            .clk       (clk),
            .rst_n     (rst_n),
            .in        (sw_in[g]),
            .in_valid  (1'b0),
            .out       (sw_out[g]),
            .out_q     (sw_q[g]),
            .out_valid (sw_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            if (aa[7]) aa = (aa << 1) ^ 8'h1b;
            else       aa = aa << 1;
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) r = 8'(y);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dvld  = 1'b0;
        din   = 8'h00;
        tick();
        tick();
        total++;
        if (dout_q !== 8'h00) $display("FAIL reset_out_q got %02h exp 00", dout_q);
        else passed++;
        total++;
        if (dout_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", dout_valid);
        else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_comb_spot();
        logic [7:0] ins [6]  = '{8'h00, 8'h01, 8'h53, 8'hff, 8'hab, 8'hc9};
        logic [7:0] exps [6] = '{8'h63, 8'h7c, 8'hed, 8'h16, 8'h62, 8'hdd};
        for (int i = 0; i < 6; i++) begin
            din = ins[i];
            #1;
            total++;
            if (dout !== exps[i]) $display("FAIL comb_spot in=%02h got %02h exp %02h", ins[i], dout, exps[i]);
            else passed++;
        end
    endtask

    task automatic test_subword();
        logic [7:0] ins [4]  = '{8'hcf, 8'h4f, 8'h3c, 8'h09};
        logic [31:0] got;
        for (int i = 0; i < 4; i++) sw_in[i] = ins[i];
        #1;
        got = {sw_out[0], sw_out[1], sw_out[2], sw_out[3]};
        total++;
        if (got !== 32'h8a84eb01) $display("FAIL subword got %08h exp 8a84eb01", got);
        else passed++;
    endtask

    task automatic test_sweep();
        bit seen [256];
        int bad_model;
        int dup;
        int fixed;
        logic [7:0] e;
        bad_model = 0;
        dup = 0;
        fixed = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int x = 0; x < 256; x++) begin
            din = 8'(x);
            #1;
            e = ref_sbox(8'(x));
            total++;
            if (dout !== e) begin
                $display("FAIL sweep_model in=%02h got %02h exp %02h", x, dout, e);
                bad_model++;
            end else passed++;
            if (!$isunknown(dout)) begin
                if (seen[dout]) dup++;
                seen[dout] = 1'b1;
            end
            if (dout === 8'(x) || dout === ~8'(x)) fixed++;
        end
        total++;
        if (dup !== 0) $display("FAIL sweep_distinct got %0d duplicates exp 0", dup);
        else passed++;
        total++;
        if (fixed !== 0) $display("FAIL sweep_fixed_points got %0d exp 0", fixed);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] ins [3]  = '{8'h00, 8'h01, 8'h53};
        logic [7:0] exps [3] = '{8'h63, 8'h7c, 8'hed};
        dvld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = ins[i];
            tick();
            total++;
            if (dout_q !== exps[i] || dout_valid !== 1'b1)
                $display("FAIL b2b_%0d got q=%02h v=%b exp q=%02h v=1", i, dout_q, dout_valid, exps[i]);
            else passed++;
        end
        dvld = 1'b0;
        din  = 8'hab;
        tick();
        total++;
        if (dout_q !== 8'hed || dout_valid !== 1'b0)
            $display("FAIL b2b_drop got q=%02h v=%b exp q=ed v=0", dout_q, dout_valid);
        else passed++;
    endtask

    task automatic test_random();
        logic [7:0] exp_q;
        logic       exp_v;
        exp_q = dout_q;
        for (int n = 0; n < 200; n++) begin
            din  = 8'($urandom_range(0, 255));
            dvld = ($urandom_range(0, 3) != 0);
            if (dvld) exp_q = ref_sbox(din);
            exp_v = dvld;
            tick();
            total++;
            if (dout_q !== exp_q || dout_valid !== exp_v)
                $display("FAIL random_%0d got q=%02h v=%b exp q=%02h v=%b", n, dout_q, dout_valid, exp_q, exp_v);
            else passed++;
        end
        dvld = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        dvld  = 1'b1;
        din   = 8'h53;
        rst_n = 1'b0;
        tick();
        total++;
        if (dout_q !== 8'h00 || dout_valid !== 1'b0)
            $display("FAIL reset_mid got q=%02h v=%b exp q=00 v=0", dout_q, dout_valid);
        else passed++;
        total++;
        if (dout !== 8'hed) $display("FAIL reset_mid_comb got %02h exp ed", dout);
        else passed++;
        dvld  = 1'b0;
        rst_n = 1'b1;
        tick();
        total++;
        if (dout_valid !== 1'b0 || dout_q !== 8'h00)
            $display("FAIL reset_release got q=%02h v=%b exp q=00 v=0", dout_q, dout_valid);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        dvld   = 1'b0;
        din    = 8'h00;
        for (int i = 0; i < 4; i++) sw_in[i] = 8'h00;
        @(negedge clk);
        test_reset();
        test_comb_spot();
        test_subword();
        test_sweep();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
